// File: rtl/apb_regbank_if.sv
// APB4 bus bundle for the register-bank slave; the master side drives the request
// and the slave side returns the completion.
interface apb_regbank_if #(
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   PADDR;
    logic                    PSEL;
    logic                    PENABLE;
    logic                    PWRITE;
    logic [DATA_WIDTH-1:0]   PWDATA;
    logic [DATA_WIDTH/8-1:0] PSTRB;
    logic [DATA_WIDTH-1:0]   PRDATA;
    logic                    PREADY;
    logic                    PSLVERR;

    modport master (
        output PADDR, PSEL, PENABLE, PWRITE, PWDATA, PSTRB,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PADDR, PSEL, PENABLE, PWRITE, PWDATA, PSTRB,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/apb_regbank_slave.sv
// APB4 register-bank slave: byte strobes, programmable wait states, read-only slots
// fed from ro_in, full error decode and abort on PSEL/PENABLE drop.
module apb_regbank_slave #(
    parameter int unsigned        DATA_WIDTH  = 32,
    parameter int unsigned        ADDR_WIDTH  = 12,
    parameter int unsigned        REG_NUM     = 8,
    parameter int unsigned        WAIT_STATES = 1,
    parameter logic [REG_NUM-1:0] RO_MASK     = '0
) (
    input  logic                          PCLK,
    input  logic                          PRESETn,
    apb_regbank_if.slave                  apb,
    input  logic [REG_NUM*DATA_WIDTH-1:0] ro_in,
    output logic [REG_NUM*DATA_WIDTH-1:0] reg_out
);
    localparam int unsigned NB = DATA_WIDTH / 8;
    localparam int unsigned IW = $clog2(REG_NUM);
    localparam logic [ADDR_WIDTH:0] ADDR_LIMIT = (ADDR_WIDTH+1)'(4 * REG_NUM);

    localparam logic [0:0] S_IDLE   = 1'b0;
    localparam logic [0:0] S_ACCESS = 1'b1;

    logic [0:0]            state;
    logic [3:0]            cnt;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  write_q;
    logic [NB-1:0]         strb_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] regs     [REG_NUM];
    logic [DATA_WIDTH-1:0] ro_words [REG_NUM];

    logic [ADDR_WIDTH-1:0] dec_addr;
    logic                  dec_write;
    logic [IW-1:0]         dec_idx;
    logic                  dec_err;
    logic [DATA_WIDTH-1:0] dec_rdata;

    always_comb begin
        for (int unsigned i = 0; i < REG_NUM; i++) begin
            ro_words[i]                           = ro_in[i*DATA_WIDTH +: DATA_WIDTH];
            reg_out[i*DATA_WIDTH +: DATA_WIDTH]   = regs[i];
        end
    end

    // Decode uses the live bus in IDLE so a zero-wait setup can answer on its first edge.
    always_comb begin
        dec_addr  = (state == S_IDLE) ? apb.PADDR  : addr_q;
        dec_write = (state == S_IDLE) ? apb.PWRITE : write_q;
        dec_idx   = dec_addr[IW+1:2];
        dec_err   = (dec_addr[1:0] != 2'b00) || ({1'b0, dec_addr} >= ADDR_LIMIT)
                    || (dec_write && RO_MASK[dec_idx]);
        dec_rdata = '0;
        if (!dec_err && !dec_write)
            dec_rdata = RO_MASK[dec_idx] ? ro_words[dec_idx] : regs[dec_idx];
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state       <= S_IDLE;
            cnt         <= '0;
            addr_q      <= '0;
            write_q     <= 1'b0;
            strb_q      <= '0;
            wdata_q     <= '0;
            apb.PRDATA  <= '0;
            apb.PREADY  <= 1'b0;
            apb.PSLVERR <= 1'b0;
            for (int unsigned i = 0; i < REG_NUM; i++)
                regs[i] <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (apb.PSEL && !apb.PENABLE) begin
                        addr_q  <= apb.PADDR;
                        write_q <= apb.PWRITE;
                        strb_q  <= apb.PSTRB;
                        wdata_q <= apb.PWDATA;
                        cnt     <= 4'(WAIT_STATES);
                        state   <= S_ACCESS;
                        if (WAIT_STATES == 0) begin
                            apb.PREADY  <= 1'b1;
                            apb.PRDATA  <= dec_rdata;
                            apb.PSLVERR <= dec_err;
                        end
                    end
                end
                S_ACCESS: begin
                    if (!apb.PSEL || !apb.PENABLE) begin
                        state       <= S_IDLE;
                        apb.PREADY  <= 1'b0;
                        apb.PSLVERR <= 1'b0;
                        apb.PRDATA  <= '0;
                    end else if (!apb.PREADY) begin
                        cnt <= cnt - 4'd1;
                        if (cnt == 4'd1) begin
                            apb.PREADY  <= 1'b1;
                            apb.PRDATA  <= dec_rdata;
                            apb.PSLVERR <= dec_err;
                        end
                    end else begin
                        if (write_q && !dec_err) begin
                            for (int unsigned b = 0; b < NB; b++)
                                if (strb_q[b])
                                    regs[dec_idx][b*8 +: 8] <= wdata_q[b*8 +: 8];
                        end
                        state       <= S_IDLE;
                        apb.PREADY  <= 1'b0;
                        apb.PSLVERR <= 1'b0;
                        apb.PRDATA  <= '0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_apb_regbank_slave.sv
// Scoreboard bench for apb_regbank_slave: directed and random APB transfers checked
// against a word-array reference model of the register bank.
module tb_apb_regbank_slave;
    localparam int unsigned DW  = 32;
    localparam int unsigned AW  = 12;
    localparam int unsigned RN  = 8;
    localparam int unsigned WS  = 2;
    localparam logic [RN-1:0] ROM = 8'h81;

    logic PCLK = 1'b0;
    logic PRESETn = 1'b0;
    logic [RN*DW-1:0] ro_in;
    logic [RN*DW-1:0] reg_out;

    always #5 PCLK = ~PCLK;

    apb_regbank_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) apb ();

    apb_regbank_slave #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .REG_NUM(RN), .WAIT_STATES(WS), .RO_MASK(ROM)
    ) dut (
        .PCLK(PCLK), .PRESETn(PRESETn), .apb(apb), .ro_in(ro_in), .reg_out(reg_out)
    );

    typedef struct {
        string       name;
        logic [31:0] rdata;
        logic        err;
    } resp_t;

    resp_t       sb[$];
    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    logic [31:0] model    [RN];
    logic [31:0] ro_words [RN];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic void exp_resp(input logic [AW-1:0] a, input logic w,
                                     output logic [31:0] rd, output logic err);
        int unsigned idx;
        idx = 32'(a) / 4;
        err = 1'b0;
        if (32'(a) % 4 != 0 || idx >= RN) err = 1'b1;
        else if (w && ROM[idx]) err = 1'b1;
        rd = '0;
        if (!err && !w) rd = ROM[idx] ? ro_words[idx] : model[idx];
    endfunction

    task automatic set_ro();
        for (int i = 0; i < RN; i++) ro_in[i*DW +: DW] = ro_words[i];
    endtask

    task automatic check_regs(input string name);
        for (int i = 0; i < RN; i++)
            check($sformatf("%s_reg%0d", name, i), reg_out[i*DW +: DW], ROM[i] ? 32'h0 : model[i]);
    endtask

    task automatic bus_idle();
        apb.PSEL = 1'b0; apb.PENABLE = 1'b0; apb.PADDR = '0;
        apb.PWRITE = 1'b0; apb.PWDATA = '0; apb.PSTRB = '0;
    endtask

    // Monitor: every completion pops the oldest expected response.
    always @(negedge PCLK) begin
        if (PRESETn && apb.PREADY === 1'b1) begin
            if (sb.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_pready: got PREADY=1 with no transfer pending");
            end else begin
                resp_t e;
                e = sb.pop_front();
                check({e.name, "_prdata"}, apb.PRDATA, e.rdata);
                check({e.name, "_pslverr"}, 32'(apb.PSLVERR), 32'(e.err));
            end
        end
    end

    task automatic xfer(input string name, input logic [AW-1:0] a, input logic w,
                        input logic [31:0] wd, input logic [3:0] st);
        logic [31:0] rd;
        logic        err;
        int unsigned cyc;
        int unsigned idx;
        exp_resp(a, w, rd, err);
        sb.push_back('{name: name, rdata: rd, err: err});
        apb.PSEL = 1'b1; apb.PENABLE = 1'b0; apb.PADDR = a;
        apb.PWRITE = w; apb.PWDATA = wd; apb.PSTRB = st;
        @(posedge PCLK); #1;
        apb.PENABLE = 1'b1;
        cyc = 0;
        do begin
            @(negedge PCLK);
            cyc++;
        end while (apb.PREADY !== 1'b1 && cyc < 20);
        check({name, "_latency"}, cyc, WS + 1);
        @(posedge PCLK); #1;
        apb.PSEL = 1'b0; apb.PENABLE = 1'b0;
        if (w && !err) begin
            idx = 32'(a) / 4;
            for (int b = 0; b < 4; b++)
                if (st[b]) model[idx][b*8 +: 8] = wd[b*8 +: 8];
        end
        check_regs(name);
    endtask

    task automatic abort_xfer(input string name, input logic [AW-1:0] a, input logic drop_sel);
        apb.PSEL = 1'b1; apb.PENABLE = 1'b0; apb.PADDR = a;
        apb.PWRITE = 1'b1; apb.PWDATA = 32'hA5A5_5A5A; apb.PSTRB = 4'hF;
        @(posedge PCLK); #1;
        apb.PENABLE = 1'b1;
        @(posedge PCLK); #1;
        if (drop_sel) apb.PSEL = 1'b0;
        apb.PENABLE = 1'b0;
        @(posedge PCLK); #1;
        apb.PSEL = 1'b0;
        @(negedge PCLK);
        check({name, "_pready"}, 32'(apb.PREADY), 32'h0);
        repeat (2) @(posedge PCLK);
        #1;
        check_regs(name);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got simulation still running expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [AW-1:0] a;
        bus_idle();
        for (int i = 0; i < RN; i++) begin
            model[i] = '0;
            ro_words[i] = $urandom;
        end
        set_ro();
        repeat (3) @(posedge PCLK);
        #1 PRESETn = 1'b1;
        @(negedge PCLK);
        check("reset_pready", 32'(apb.PREADY), 32'h0);
        check("reset_pslverr", 32'(apb.PSLVERR), 32'h0);
        check("reset_prdata", apb.PRDATA, 32'h0);
        check_regs("reset");
        @(posedge PCLK); #1;

        xfer("wr_deadbeef", 12'h004, 1'b1, 32'hDEADBEEF, 4'hF);
        check("wr_deadbeef_slice1", reg_out[32 +: 32], 32'hDEADBEEF);
        xfer("strb_wr", 12'h004, 1'b1, 32'h11223344, 4'b0101);
        xfer("strb_rd", 12'h004, 1'b0, 32'h0, 4'h0);
        check("strb_slice1", reg_out[32 +: 32], 32'hDE22BE44);
        xfer("strb_zero", 12'h004, 1'b1, 32'hFFFFFFFF, 4'h0);
        xfer("err_oor", 12'h020, 1'b0, 32'h0, 4'h0);
        xfer("err_misalign", 12'h006, 1'b0, 32'h0, 4'h0);
        xfer("err_ro_wr", 12'h000, 1'b1, 32'h12345678, 4'hF);
        xfer("err_oor_wr", 12'hFFC, 1'b1, 32'h12345678, 4'hF);
        ro_words[0] = 32'hCAFE0001;
        set_ro();
        xfer("ro_rd", 12'h000, 1'b0, 32'h0, 4'h0);
        xfer("raw_wr", 12'h00C, 1'b1, 32'h0BADF00D, 4'hF);
        xfer("raw_rd", 12'h00C, 1'b0, 32'h0, 4'h0);

        abort_xfer("abort_psel", 12'h010, 1'b1);
        xfer("post_abort_wr", 12'h010, 1'b1, 32'h76543210, 4'hF);
        abort_xfer("abort_penable", 12'h008, 1'b0);
        xfer("post_abort_rd", 12'h010, 1'b0, 32'h0, 4'h0);

        // Reset pulse during the wait states: nothing commits and the bank clears.
        apb.PSEL = 1'b1; apb.PENABLE = 1'b0; apb.PADDR = 12'h008;
        apb.PWRITE = 1'b1; apb.PWDATA = 32'h55AA55AA; apb.PSTRB = 4'hF;
        @(posedge PCLK); #1;
        apb.PENABLE = 1'b1;
        @(posedge PCLK); #1;
        PRESETn = 1'b0;
        #2;
        bus_idle();
        for (int i = 0; i < RN; i++) model[i] = '0;
        check("rst_mid_pready", 32'(apb.PREADY), 32'h0);
        @(posedge PCLK); #1;
        PRESETn = 1'b1;
        @(negedge PCLK);
        check("rst_mid_prdata", apb.PRDATA, 32'h0);
        check_regs("rst_mid");
        @(posedge PCLK); #1;
        xfer("post_rst_wr", 12'h008, 1'b1, 32'h13579BDF, 4'hF);
        xfer("post_rst_rd", 12'h008, 1'b0, 32'h0, 4'h0);

        for (int n = 0; n < 60; n++) begin
            for (int i = 0; i < RN; i++) ro_words[i] = $urandom;
            set_ro();
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4, 5, 6: a = AW'($urandom_range(0, RN - 1) * 4);
                7:       a = AW'($urandom_range(0, RN - 1) * 4 + $urandom_range(1, 3));
                8:       a = AW'($urandom_range(RN, 1023) * 4);
                default: a = AW'($urandom);
            endcase
            xfer($sformatf("rnd%0d", n), a, 1'($urandom_range(0, 1)), $urandom, 4'($urandom));
            if ($urandom_range(0, 1) == 1) begin
                @(posedge PCLK); #1;
            end
        end

        repeat (3) @(negedge PCLK);
        check("sb_drain", sb.size(), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
